// File: rtl/instr_fetch_seq.sv
// Purpose: fetch/sequencing stage ahead of the MCU; owns the PC, fetches over req/ack, latches IR, computes next PC.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC) with zero-wait ack; +1 per ack wait cycle or stall cycle.
// Backpressure: FETCH holds req/addr until imem_ack; EXEC holds (PC frozen) while stall is high; HALT exits only via rst.
module instr_fetch_seq #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [1:0]        opt_code,
    output logic [3:0]        func_code,
    output logic [4:0]        rd,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [15:0]       imm,
    output logic              instr_valid,
    output logic              exec_stb,
    input  logic              PC_input,
    input  logic [1:0]        assign_PC,
    input  logic              cmp_for_leap,
    input  logic              cmp_flag,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [ADDR_W-1:0] dm_target,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    // All-ones opcode+func marks the halt instruction.
    localparam logic [5:0] HALT_OPC = 6'b111111;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] next_pc;

    // Next PC: sequential or one of four redirect sources; wraps mod 2^ADDR_W, always word aligned.
    always_comb begin
        logic        take;
        logic [31:0] rel_off;
        logic [31:0] imm_zx;
        logic [ADDR_W-1:0] raw;
        take    = PC_input & (~cmp_for_leap | cmp_flag);
        rel_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        imm_zx  = {16'd0, ir_q[15:0]};
        raw     = pc_q + ADDR_W'(4);
        if (take) begin
            case (assign_PC)
                2'b00:   raw = pc_q + ADDR_W'(4) + rel_off[ADDR_W-1:0];
                2'b01:   raw = dm_target;
                2'b10:   raw = reg_target;
                default: raw = imm_zx[ADDR_W-1:0];
            endcase
        end
        next_pc = {raw[ADDR_W-1:2], 2'b00};
    end

    // Sequencer next-state: advance on ack, halt on the halt opcode, retire when EXEC is not stalled.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (ir_q[31:26] == HALT_OPC) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // State, PC and IR registers; synchronous reset wins over any pending ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Moore outputs decoded from the registered state; handshake strobes are suppressed during reset.
    assign imem_req    = (state_q == S_FETCH)  & ~rst;
    assign instr_valid = (state_q == S_DECODE) & ~rst;
    assign exec_stb    = (state_q == S_EXEC)   & ~rst;
    assign halted      = (state_q == S_HALT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;

    // Instruction fields come straight from IR and therefore hold until the next ack.
    assign opt_code  = ir_q[31:30];
    assign func_code = ir_q[29:26];
    assign rd        = ir_q[25:21];
    assign rs1       = ir_q[20:16];
    assign rs2       = ir_q[15:11];
    assign imm       = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [1:0]    opt_code;
    logic [3:0]    func_code;
    logic [4:0]    rd, rs1, rs2;
    logic [15:0]   imm;
    logic          instr_valid, exec_stb;
    logic          PC_input;
    logic [1:0]    assign_PC;
    logic          cmp_for_leap, cmp_flag;
    logic [AW-1:0] reg_target, dm_target;
    logic          stall;
    logic [AW-1:0] pc;
    logic          halted;

    instr_fetch_seq #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .opt_code(opt_code), .func_code(func_code), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .instr_valid(instr_valid), .exec_stb(exec_stb),
        .PC_input(PC_input), .assign_PC(assign_PC), .cmp_for_leap(cmp_for_leap), .cmp_flag(cmp_flag),
        .reg_target(reg_target), .dm_target(dm_target), .stall(stall),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    logic [31:0] exp_fetch_q[$];
    logic [31:0] exp_ir_q[$];
    int          exp_gap_q[$];
    int          exp_exec_q[$];
    bit          mon_en = 1'b0;

    // Reference-model state.
    int model_pc = 0;
    bit first    = 1'b1;
    int s_prev   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural next-PC rule in plain integer arithmetic.
    function automatic int ref_next(input int cur, input logic [31:0] ir, input bit pin, input int apc,
                                    input bit cfl, input bit cf, input int rt, input int dt);
        int n;
        int imm_s;
        imm_s = int'($signed(ir[15:0]));
        if (!(pin && (!cfl || cf))) n = cur + 4;
        else begin
            case (apc)
                0:       n = cur + 4 + imm_s * 4;
                1:       n = dt;
                2:       n = rt;
                default: n = int'(ir[15:0]);
            endcase
        end
        n = n & ((1 << AW) - 1);
        n = n & ~3;
        return n;
    endfunction

    // Serve one instruction fetch and its EXEC phase; called at posedge+1 with the DUT in FETCH.
    task automatic do_instr(input logic [31:0] ir, input int w, input int s, input bit pin, input int apc,
                            input bit cfl, input bit cf, input int rt, input int dt);
        int t;
        t = 0;
        while (imem_req !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (imem_req !== 1'b1) begin
            chk("fetch_timeout", {31'd0, imem_req}, 32'd1);
            return;
        end
        exp_fetch_q.push_back(model_pc);
        exp_gap_q.push_back(first ? -1 : 3 + s_prev + w);
        repeat (w) begin @(posedge clk); #1; end
        imem_ack     = 1'b1;
        imem_rdata   = ir;
        PC_input     = pin;
        assign_PC    = 2'(apc);
        cmp_for_leap = cfl;
        cmp_flag     = cf;
        reg_target   = rt[AW-1:0];
        dm_target    = dt[AW-1:0];
        stall        = (s > 0);
        exp_ir_q.push_back(ir);
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (ir[31:26] == 6'h3F) begin
            @(posedge clk); #1;
            stall = 1'b0;
            return;
        end
        @(posedge clk); #1;
        repeat (s) begin @(posedge clk); #1; end
        stall = 1'b0;
        exp_exec_q.push_back(s + 1);
        model_pc = ref_next(model_pc, ir, pin, apc, cfl, cf, rt, dt);
        @(posedge clk); #1;
        first  = 1'b0;
        s_prev = s;
    endtask

    // Monitor: compares DUT outputs against the scoreboard whenever a strobe is presented.
    initial begin
        int run;
        int g;
        int last_acc;
        logic [31:0] cur_pc;
        logic [31:0] cur_ir;
        logic [31:0] e;
        run = 0; last_acc = 0; cur_pc = '0; cur_ir = '0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                run = 0;
                continue;
            end
            if (imem_req) begin
                if (exp_fetch_q.size() == 0) chk("unexpected_fetch", {31'd0, imem_req}, 32'd0);
                else begin
                    chk("fetch_addr", {24'd0, imem_addr}, exp_fetch_q[0]);
                    if (imem_ack) begin
                        cur_pc = exp_fetch_q.pop_front();
                        chk("pc_at_fetch", {24'd0, pc}, cur_pc);
                        g = exp_gap_q.pop_front();
                        if (g >= 0) chk("fetch_gap", cyc - last_acc, g);
                        last_acc = cyc;
                    end else begin
                        chk("no_valid_while_wait", {31'd0, instr_valid}, 32'd0);
                    end
                end
            end
            if (instr_valid) begin
                if (exp_ir_q.size() == 0) chk("unexpected_valid", {31'd0, instr_valid}, 32'd0);
                else begin
                    e = exp_ir_q.pop_front();
                    cur_ir = e;
                    chk("opt_code", {30'd0, opt_code}, {30'd0, e[31:30]});
                    chk("func_code", {28'd0, func_code}, {28'd0, e[29:26]});
                    chk("rd", {27'd0, rd}, {27'd0, e[25:21]});
                    chk("rs1", {27'd0, rs1}, {27'd0, e[20:16]});
                    chk("rs2", {27'd0, rs2}, {27'd0, e[15:11]});
                    chk("imm", {16'd0, imm}, {16'd0, e[15:0]});
                end
            end
            if (exec_stb) begin
                run++;
                chk("pc_hold_exec", {24'd0, pc}, cur_pc);
                chk("fields_hold_exec", {opt_code, func_code, rd, rs1, imm}, cur_ir);
            end else if (run > 0) begin
                if (exp_exec_q.size() == 0) chk("unexpected_exec", run, 0);
                else chk("exec_len", run, exp_exec_q.pop_front());
                run = 0;
            end
        end
    end

    // Stimulus: reset, directed scenarios, randomized instruction stream, halt and reset recovery.
    initial begin
        logic [31:0] ir;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; PC_input = 1'b0; assign_PC = 2'b00;
        cmp_for_leap = 1'b0; cmp_flag = 1'b0; reg_target = '0; dm_target = '0; stall = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_opt_code", {30'd0, opt_code}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_exec_stb", {31'd0, exec_stb}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", {24'd0, imem_addr}, 32'd0);
        @(posedge clk); #1;
        model_pc = 0; first = 1'b1; mon_en = 1'b1;

        do_instr(32'h0C000000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_pc", {24'd0, pc}, 32'h04);
        do_instr(32'h12345678, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_pc", {24'd0, pc}, 32'h08);
        do_instr(32'h00000010, 0, 0, 1, 3, 0, 0, 0, 0);
        chk("jump_abs", {24'd0, pc}, 32'h10);
        do_instr(32'h0400FFFE, 0, 0, 1, 0, 1, 0, 0, 0);
        chk("t4_not_taken", {24'd0, pc}, 32'h14);
        do_instr(32'h00000010, 1, 0, 1, 3, 0, 0, 0, 0);
        do_instr(32'h0400FFFE, 0, 0, 1, 0, 1, 1, 0, 0);
        chk("t4_taken", {24'd0, pc}, 32'h0C);
        do_instr(32'h000000FC, 0, 0, 1, 3, 0, 0, 0, 0);
        chk("jump_fc", {24'd0, pc}, 32'hFC);
        do_instr(32'h08000000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_wrap", {24'd0, pc}, 32'h00);
        do_instr(32'h40000000, 0, 0, 1, 2, 0, 0, 32'h37, 32'h11);
        chk("t5_reg_target", {24'd0, pc}, 32'h34);
        do_instr(32'h40000000, 2, 0, 1, 1, 0, 0, 32'h22, 32'h5B);
        chk("dm_target", {24'd0, pc}, 32'h58);
        do_instr(32'h000000A0, 0, 0, 1, 3, 1, 0, 0, 0);
        chk("cond_not_taken", {24'd0, pc}, 32'h5C);
        do_instr(32'h87654321, 0, 2, 0, 0, 0, 0, 0, 0);
        chk("t6_stall_pc", {24'd0, pc}, 32'h60);

        for (int i = 0; i < 60; i++) begin
            ir = $urandom;
            if (ir[31:26] == 6'h3F) ir[26] = 1'b0;
            do_instr(ir, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        do_instr(32'hFC000000, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            chk("halt_no_exec", {31'd0, exec_stb}, 32'd0);
        end
        chk("halt_q_ir", exp_ir_q.size(), 0);
        chk("halt_q_fetch", exp_fetch_q.size(), 0);

        @(posedge clk); #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("halt_rst_pc", {24'd0, pc}, 32'd0);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("halt_rst_req", {31'd0, imem_req}, 32'd1);
        chk("halt_rst_addr", {24'd0, imem_addr}, 32'd0);

        // Reset coincident with an ack: the fetched halt word must be discarded.
        @(posedge clk); #1;
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFC000000;
        @(posedge clk); #1;
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);
        chk("rst_ack_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_ack_req", {31'd0, imem_req}, 32'd1);
        chk("rst_ack_opt", {30'd0, opt_code}, 32'd0);
        @(negedge clk);
        chk("rst_ack_halted", {31'd0, halted}, 32'd0);

        @(posedge clk); #1;
        model_pc = 0; first = 1'b1; mon_en = 1'b1;
        do_instr(32'h0C000003, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("final_pc", {24'd0, pc}, 32'h10);
        exp_fetch_q.push_back(model_pc);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("end_q_exec", exp_exec_q.size(), 0);
        chk("end_q_ir", exp_ir_q.size(), 0);
        chk("end_q_fetch", exp_fetch_q.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
